// File: rtl/xspi_pkg.sv
// Shared definitions for the xSPI request bridge: command bytes, FSM states and
// the layout of a queued host request.
package xspi_pkg;

   localparam logic [7:0]  CMD_RD_DEF  = 8'hFF;
   localparam logic [7:0]  CMD_WR_DEF  = 8'hA5;
   localparam int unsigned XSPI_ADDR_W = 48;
   localparam int unsigned DATA_W      = 64;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic                   write;
      logic [XSPI_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]      wdata;
   } req_t;

   localparam int unsigned REQ_W = $bits(req_t);

endpackage

// File: rtl/xspi_req_fifo.sv
// Request FIFO with count-based full/empty; reads are combinational from the head.
// A push while full is dropped, even when a pop happens in the same cycle.
module xspi_req_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/xspi_req_bridge.sv
// Host request stage for the xSPI controller: queues requests, issues them one at
// a time, waits for done or timeout, and returns a response on a valid/ready channel.
module xspi_req_bridge
   import xspi_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADDR_W     = 48,
   parameter int unsigned TIMEOUT    = 64,
   parameter logic [7:0]  CMD_RD     = CMD_RD_DEF,
   parameter logic [7:0]  CMD_WR     = CMD_WR_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [63:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              xspi_start,
   output logic [7:0]        xspi_command,
   output logic [47:0]       xspi_address,
   output logic [63:0]       xspi_wr_data,
   input  logic [63:0]       xspi_rd_data,
   input  logic              xspi_done,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   state_t           state;
   req_t             req_in;
   req_t             head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic             is_write;
   logic [CNT_W-1:0] cnt;

   always_comb begin
      req_in                    = '0;
      req_in.write              = req_write;
      req_in.addr[ADDR_W-1:0]   = req_addr;
      req_in.wdata              = req_wdata;
   end

   assign req_ready = !fifo_full;
   assign fifo_pop  = (state == IDLE) && !fifo_empty;
   assign busy      = (state != IDLE) || !fifo_empty;

   xspi_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REQ_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (req_valid && req_ready),
      .pop   (fifo_pop),
      .din   (req_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         is_write     <= 1'b0;
         cnt          <= '0;
         xspi_start   <= 1'b0;
         xspi_command <= '0;
         xspi_address <= '0;
         xspi_wr_data <= '0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  is_write     <= head.write;
                  xspi_command <= head.write ? CMD_WR : CMD_RD;
                  xspi_address <= head.addr;
                  xspi_wr_data <= head.wdata;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               xspi_start <= 1'b1;
               cnt        <= '0;
               state      <= WAIT;
            end
            WAIT: begin
               xspi_start <= 1'b0;
               // done is tested first so it wins over a coincident timeout
               if (xspi_done) begin
                  rsp_rdata <= is_write ? '0 : xspi_rd_data;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xspi_req_bridge.sv
// Scoreboard bench for xspi_req_bridge with a behavioural xSPI controller model.
module tb_xspi_req_bridge;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [47:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic        xspi_start;
   logic [7:0]  xspi_command;
   logic [47:0] xspi_address;
   logic [63:0] xspi_wr_data;
   logic [63:0] xspi_rd_data = '0;
   logic        xspi_done = 1'b0;
   logic        busy;

   always #5 clk = ~clk;

   xspi_req_bridge #(
      .FIFO_DEPTH (4),
      .ADDR_W     (48),
      .TIMEOUT    (TMO),
      .CMD_RD     (8'hFF),
      .CMD_WR     (8'hA5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .xspi_start   (xspi_start),
      .xspi_command (xspi_command),
      .xspi_address (xspi_address),
      .xspi_wr_data (xspi_wr_data),
      .xspi_rd_data (xspi_rd_data),
      .xspi_done    (xspi_done),
      .busy         (busy)
   );

   typedef struct {
      logic [7:0]  cmd;
      logic [47:0] addr;
      logic [63:0] wdata;
      int          delay;
      logic [63:0] rdata;
      bit          do_done;
   } plan_t;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } rsp_t;

   plan_t plan_q[$];
   rsp_t  exp_q[$];
   plan_t cp;
   rsp_t  er;
   int    total = 0;
   int    bad = 0;
   int    starts = 0;
   logic  prev_start = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: a handshake seen at negedge completes on the next posedge.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got rdata=%h err=%b with nothing expected", rsp_rdata, rsp_err);
         end else begin
            er = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, er.rdata);
            chk("rsp_err", {63'd0, rsp_err}, {63'd0, er.err});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && xspi_start) begin
         starts++;
         chk("start_one_cycle", {63'd0, prev_start}, 64'd0);
      end
      prev_start <= xspi_start;
   end

   // Controller model: answers each start according to the next queued plan.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && xspi_start) begin
            if (plan_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_start: got cmd=%h addr=%h with no request pending", xspi_command, xspi_address);
            end else begin
               cp = plan_q.pop_front();
               chk("xspi_command", {56'd0, xspi_command}, {56'd0, cp.cmd});
               chk("xspi_address", {16'd0, xspi_address}, {16'd0, cp.addr});
               chk("xspi_wr_data", xspi_wr_data, cp.wdata);
               if (cp.do_done) begin
                  repeat (cp.delay) @(posedge clk);
                  #1;
                  xspi_rd_data = cp.rdata;
                  xspi_done = 1'b1;
                  @(negedge clk);
                  chk("wr_data_stable", xspi_wr_data, cp.wdata);
                  chk("command_stable", {56'd0, xspi_command}, {56'd0, cp.cmd});
                  @(posedge clk);
                  #1;
                  xspi_done = 1'b0;
                  xspi_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
                  if (cp.delay < TMO) begin
                     @(negedge clk);
                     chk("done_to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
                  end
               end
            end
         end
      end
   end

   task automatic send(input logic wr, input logic [47:0] addr, input logic [63:0] wd,
                       input int delay, input logic [63:0] crd, input bit do_done,
                       input logic [63:0] exp_rd, input logic exp_err);
      plan_t p;
      rsp_t  r;
      bit    ok;
      p.cmd     = wr ? 8'hA5 : 8'hFF;
      p.addr    = addr;
      p.wdata   = wd;
      p.delay   = delay;
      p.rdata   = crd;
      p.do_done = do_done;
      plan_q.push_back(p);
      r.rdata = exp_rd;
      r.err   = exp_err;
      exp_q.push_back(r);
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL send_accept: got req_ready=0 for 300 cycles expected acceptance of addr %h", addr);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
      chk("drain_queue", 64'(exp_q.size()), 64'd0);
      chk("drain_busy", {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
      chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
      chk({tag, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
      chk({tag, "_xspi_start"}, {63'd0, xspi_start}, 64'd0);
      chk({tag, "_xspi_command"}, {56'd0, xspi_command}, 64'd0);
      chk({tag, "_xspi_address"}, {16'd0, xspi_address}, 64'd0);
      chk({tag, "_xspi_wr_data"}, xspi_wr_data, 64'd0);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected completion within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0;
      int n;
      repeat (3) @(posedge clk);
      #1;
      check_reset("por");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // read with start latency check
      send(1'b0, 48'h0000_0000_1234, 64'd0, 17, 64'hDEAD_BEEF_0123_4567, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0);
      @(negedge clk);
      chk("t1_start_lat0", {63'd0, xspi_start}, 64'd0);
      chk("t1_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      chk("t1_start_lat1", {63'd0, xspi_start}, 64'd0);
      @(negedge clk);
      chk("t1_start_lat2", {63'd0, xspi_start}, 64'd1);
      drain();

      // write: rd_data from the controller must not leak into the response
      send(1'b1, 48'h0000_0000_000A, 64'h1122_3344_5566_7788, 6, 64'hFFFF_0000_FFFF_0000, 1'b1, 64'd0, 1'b0);
      drain();

      // backpressure
      rsp_ready = 1'b0;
      s0 = starts;
      send(1'b0, 48'h100, 64'd0, 10, 64'h1111_1111_1111_1111, 1'b1, 64'h1111_1111_1111_1111, 1'b0);
      send(1'b1, 48'h200, 64'hAAAA_BBBB_CCCC_DDDD, 3, 64'h9999, 1'b1, 64'd0, 1'b0);
      send(1'b0, 48'h300, 64'd0, 5, 64'h3333_3333_3333_3333, 1'b1, 64'h3333_3333_3333_3333, 1'b0);
      send(1'b0, 48'h400, 64'd0, 3, 64'h4444_4444_4444_4444, 1'b1, 64'h4444_4444_4444_4444, 1'b0);
      send(1'b1, 48'h500, 64'h5, 4, 64'h7, 1'b1, 64'd0, 1'b0);
      @(negedge clk);
      chk("t3_full_not_ready", {63'd0, req_ready}, 64'd0);
      chk("t3_busy", {63'd0, busy}, 64'd1);
      repeat (30) @(negedge clk);
      chk("t3_single_start", 64'(starts - s0), 64'd1);
      chk("t3_rsp_held_valid", {63'd0, rsp_valid}, 64'd1);
      chk("t3_rsp_held_data", rsp_rdata, 64'h1111_1111_1111_1111);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      drain();
      chk("t3_start_count", 64'(starts - s0), 64'd5);

      // timeout, then a spurious done in IDLE
      send(1'b0, 48'h3000, 64'd0, 0, 64'd0, 1'b0, 64'd0, 1'b1);
      for (int i = 0; i < 20 && !xspi_start; i++) @(negedge clk);
      n = 0;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t4_timeout_cycles", 64'(n), 64'd64);
      drain();
      xspi_rd_data = 64'hFEED_FEED_FEED_FEED;
      xspi_done = 1'b1;
      @(posedge clk);
      #1;
      xspi_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("t4_spurious_ignored", {63'd0, rsp_valid}, 64'd0);
      @(posedge clk);
      #1;
      // done one cycle too late lands in RESP and is ignored
      send(1'b0, 48'h3100, 64'd0, 64, 64'h5555_5555_5555_5555, 1'b1, 64'd0, 1'b1);
      drain();
      send(1'b0, 48'h3200, 64'd0, 4, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
      drain();

      // done on the last WAIT cycle beats the timeout
      send(1'b0, 48'h4000, 64'd0, 63, 64'hCAFE_F00D_CAFE_F00D, 1'b1, 64'hCAFE_F00D_CAFE_F00D, 1'b0);
      drain();

      // reset mid-WAIT with three queued requests
      s0 = starts;
      send(1'b0, 48'h6000, 64'd0, 0, 64'd0, 1'b0, 64'd0, 1'b1);
      send(1'b0, 48'h6100, 64'd0, 3, 64'h1, 1'b1, 64'h1, 1'b0);
      send(1'b1, 48'h6200, 64'h2, 3, 64'h2, 1'b1, 64'd0, 1'b0);
      send(1'b0, 48'h6300, 64'd0, 3, 64'h3, 1'b1, 64'h3, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      plan_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6_busy", {63'd0, busy}, 64'd0);
      chk("t6_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("t6_req_ready", {63'd0, req_ready}, 64'd1);
      chk("t6_no_restart", 64'(starts - s0), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
